// File: rtl/scan_mux_reg.sv
//==============================================================================
// Module      : scan_mux_reg
// Description : Registered N-channel, W-bit multiplexer with output enable.
//               Manual mode selects a channel with sel. Scan mode walks an
//               internal pointer round-robin over all channels and dwells
//               DWELL cycles on each one. All outputs are registered.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module scan_mux_reg #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1,
  localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  input  logic [CHANNELS*WIDTH-1:0] mux_in,
  output logic [WIDTH-1:0]          mux_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      valid,
  output logic                      wrap
);

  // Dwell counter only needs to reach DWELL-1; keep at least one bit.
  localparam int c_dcnt_w = (DWELL > 2) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W-1:0]    c_last_chan  = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0]    c_ptr_one    = SEL_W'(1);
  localparam logic [c_dcnt_w-1:0] c_last_dwell = c_dcnt_w'(DWELL - 1);
  localparam logic [c_dcnt_w-1:0] c_dcnt_one   = c_dcnt_w'(1);

  // Channel view of the flat input bus
  logic [WIDTH-1:0]    w_ch [CHANNELS];

  // Registered state
  logic                r_mode_q;
  logic [SEL_W-1:0]    r_ptr;
  logic [c_dcnt_w-1:0] r_dcnt;
  logic [WIDTH-1:0]    r_mux_out;
  logic [SEL_W-1:0]    r_chan_out;
  logic                r_valid;
  logic                r_wrap;

  // Combinational helpers
  logic [WIDTH-1:0]    w_man_data;
  logic                w_man_ok;
  logic [WIDTH-1:0]    w_scan_data;
  logic                w_entry;
  logic                w_advance;
  logic [SEL_W-1:0]    w_ptr_eff;
  logic [c_dcnt_w-1:0] w_dcnt_eff;
  logic                w_dwell_done;
  logic                w_at_last;
  logic [SEL_W-1:0]    w_ptr_next;
  logic [c_dcnt_w-1:0] w_dcnt_inc;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_unpack
      assign w_ch[k] = mux_in[k*WIDTH +: WIDTH];
    end
  endgenerate

  // Manual select: decoded compare so out-of-range codes yield "no channel"
  always_comb begin
    w_man_data = '0;
    w_man_ok   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) begin
        w_man_data = w_ch[i];
        w_man_ok   = 1'b1;
      end
    end
  end

  // A rising mode edge restarts the scan from channel 0 with a fresh dwell
  assign w_entry    = mode & ~r_mode_q;
  assign w_ptr_eff  = w_entry ? '0 : r_ptr;
  assign w_dcnt_eff = w_entry ? '0 : r_dcnt;

  // Entry outranks hold, so an entry edge always counts as a dwell step
  assign w_advance    = w_entry | ~hold;
  assign w_dwell_done = (w_dcnt_eff == c_last_dwell);
  assign w_at_last    = (w_ptr_eff == c_last_chan);
  assign w_ptr_next   = w_at_last ? '0 : (w_ptr_eff + c_ptr_one);
  assign w_dcnt_inc   = w_dcnt_eff + c_dcnt_one;

  // Scan data mux, pointer is always below CHANNELS
  always_comb begin
    w_scan_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_ptr_eff == SEL_W'(i)) begin
        w_scan_data = w_ch[i];
      end
    end
  end

  // Previous-mode register used to detect scan entry, updates every edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode_q <= 1'b0;
    end else begin
      r_mode_q <= mode;
    end
  end

  // Scan pointer and dwell counter; frozen when disabled, in manual or on hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_dcnt <= '0;
    end else if (enable && mode && w_advance) begin
      if (w_dwell_done) begin
        r_dcnt <= '0;
        r_ptr  <= w_ptr_next;
      end else begin
        r_dcnt <= w_dcnt_inc;
        r_ptr  <= w_ptr_eff;
      end
    end
  end

  // Output register: disable forces zero, manual or scan otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mux_out  <= '0;
      r_chan_out <= '0;
      r_valid    <= 1'b0;
      r_wrap     <= 1'b0;
    end else if (!enable) begin
      r_mux_out <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (!mode) begin
      r_wrap <= 1'b0;
      if (w_man_ok) begin
        r_mux_out  <= w_man_data;
        r_chan_out <= sel;
        r_valid    <= 1'b1;
      end else begin
        r_mux_out <= '0;
        r_valid   <= 1'b0;
      end
    end else begin
      r_mux_out  <= w_scan_data;
      r_chan_out <= w_ptr_eff;
      r_valid    <= 1'b1;
      r_wrap     <= w_advance & w_dwell_done & w_at_last;
    end
  end

  assign mux_out  = r_mux_out;
  assign chan_out = r_chan_out;
  assign valid    = r_valid;
  assign wrap     = r_wrap;

endmodule

`default_nettype wire
